// File: rtl/mem_d1_sweeper_pkg.sv
// Shared types and constants for the std_mem_d1 range sweeper.
package mem_d1_sweeper_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_RD,
    S_FIN
  } sweep_state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_SUM  = 1'b1;

endpackage

// File: rtl/mem_d1_sweeper_if.sv
// One-ported std_mem_d1 bus: master drives address/data/enable, slave returns data/done.
interface mem_d1_sweeper_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] mem_addr0;
  logic [WIDTH-1:0]    mem_write_data;
  logic                mem_write_en;
  logic [WIDTH-1:0]    mem_read_data;
  logic                mem_done;

  modport master (
    output mem_addr0, mem_write_data, mem_write_en,
    input  mem_read_data, mem_done
  );

  modport slave (
    input  mem_addr0, mem_write_data, mem_write_en,
    output mem_read_data, mem_done
  );
endinterface

// File: rtl/mem_d1_sweeper_ctr.sv
// Element index and address register shared by FILL and SUM sweeps.
module sweep_ctr #(
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                inc,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   count,
  output logic [IDX_SIZE-1:0] addr,
  output logic                last
);
  logic [IDX_SIZE:0] idx;
  logic [IDX_SIZE:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx  <= '0;
      cnt  <= '0;
      addr <= '0;
    end else if (load) begin
      idx  <= '0;
      cnt  <= count;
      addr <= base;
    end else if (inc) begin
      idx  <= idx + (IDX_SIZE+1)'(1);
      addr <= addr + IDX_SIZE'(1);
    end
  end

  // High while the current element is the final one of the range.
  assign last = (idx + (IDX_SIZE+1)'(1)) == cnt;

endmodule

// File: rtl/mem_d1_sweeper.sv
// Bulk FILL / SUM initiator for a std_mem_d1 memory, started by a go/done handshake.
module mem_d1_sweeper
  import mem_d1_sweeper_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                mode,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   count,
  input  logic [WIDTH-1:0]    fill_val,
  input  logic [WIDTH-1:0]    step,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [WIDTH-1:0]    result,
  mem_d1_sweeper_if.master    mem
);
  sweep_state_t state, next_state;

  logic [WIDTH-1:0]    val_q;
  logic [WIDTH-1:0]    step_q;
  logic [IDX_SIZE-1:0] addr;
  logic                last;
  logic                start;
  logic                ld;
  logic                inc;
  logic                we;
  logic [IDX_SIZE+1:0] span;
  logic                range_err;

  // Two extra bits so base + count never wraps before the bound check.
  assign span      = {2'b00, base} + {1'b0, count};
  assign range_err = span > (IDX_SIZE+2)'(SIZE);

  sweep_ctr #(.IDX_SIZE(IDX_SIZE)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (ld),
    .inc   (inc),
    .base  (base),
    .count (count),
    .addr  (addr),
    .last  (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    ld         = 1'b0;
    inc        = 1'b0;
    we         = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          start = 1'b1;
          ld    = 1'b1;
          if (range_err || count == '0) next_state = S_FIN;
          else if (mode == MODE_SUM)    next_state = S_RD;
          else                          next_state = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        we         = 1'b1;
        next_state = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem.mem_done) begin
          inc        = 1'b1;
          next_state = last ? S_FIN : S_WR_ISSUE;
        end
      end
      S_RD: begin
        inc        = 1'b1;
        next_state = last ? S_FIN : S_RD;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Running adder supplies fill_val + i*step without a multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q  <= '0;
      step_q <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (start) begin
      val_q  <= fill_val;
      step_q <= step;
      result <= '0;
      err    <= range_err;
    end else if (state == S_WR_WAIT && mem.mem_done) begin
      val_q <= val_q + step_q;
    end else if (state == S_RD) begin
      result <= result + mem.mem_read_data;
    end
  end

  assign busy               = state != S_IDLE;
  assign done               = state == S_FIN;
  assign mem.mem_write_en   = we;
  assign mem.mem_addr0      = (state == S_IDLE || state == S_FIN) ? '0 : addr;
  assign mem.mem_write_data = (state == S_WR_ISSUE || state == S_WR_WAIT) ? val_q : '0;

endmodule
